// File: rtl/lsu.sv
// RV32I load/store unit: turns execute-stage memory ops into one data-memory request,
// then returns aligned, extended load data to writeback or aborts on timeout.
module lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_valid_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [2:0]  x_funct3_i,
   input  logic [31:0] x_addr_i,
   input  logic [31:0] x_store_data_i,
   input  logic [4:0]  x_rd_i,
   output logic        stall_o,
   output logic        dm_req_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wen_o,
   output logic [31:0] dm_din_o,
   input  logic [31:0] dm_dout_i,
   input  logic        dm_ack_i,
   output logic        m_valid_o,
   output logic [4:0]  m_rd_o,
   output logic [31:0] m_load_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wen_q, din_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [4:0]  rd_q;
   logic        is_load_q;
   logic        m_valid_q, misalign_q, bus_err_q;
   logic [4:0]  m_rd_q;
   logic [31:0] m_data_q;

   logic        legal_f3, op_ok, misaligned, accept, busy, timeout_hit, wb_fire;
   logic [31:0] wen_n, din_n, load_ext, lane_sh;
   logic [15:0] lane_h;

   assign busy = (state_q == S_BUSY);

   always_comb begin
      legal_f3 = 1'b0;
      if (x_load_i) begin
         legal_f3 = (x_funct3_i == 3'b000) || (x_funct3_i == 3'b001) || (x_funct3_i == 3'b010) ||
                    (x_funct3_i == 3'b100) || (x_funct3_i == 3'b101);
      end else begin
         legal_f3 = (x_funct3_i == 3'b000) || (x_funct3_i == 3'b001) || (x_funct3_i == 3'b010);
      end
      op_ok      = !busy && x_valid_i && (x_load_i ^ x_store_i) && legal_f3;
      misaligned = ((x_funct3_i[1:0] == 2'b01) && x_addr_i[0]) ||
                   ((x_funct3_i[1:0] == 2'b10) && (x_addr_i[1:0] != 2'b00));
      accept     = op_ok && !misaligned;
   end

   // Lane placement: data is replicated so the mask alone selects the written bytes.
   always_comb begin
      wen_n = 32'h0;
      din_n = x_store_data_i;
      case (x_funct3_i[1:0])
         2'b00: begin
            din_n = {4{x_store_data_i[7:0]}};
            wen_n = 32'h0000_00FF << {x_addr_i[1:0], 3'b000};
         end
         2'b01: begin
            din_n = {2{x_store_data_i[15:0]}};
            wen_n = x_addr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         end
         default: wen_n = 32'hFFFF_FFFF;
      endcase
      if (!x_store_i) wen_n = 32'h0;
   end

   always_comb begin
      lane_sh  = dm_dout_i >> {off_q, 3'b000};
      lane_h   = off_q[1] ? dm_dout_i[31:16] : dm_dout_i[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{lane_sh[7]}}, lane_sh[7:0]};
         3'b100:  load_ext = {24'h0, lane_sh[7:0]};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_ext = {16'h0, lane_h};
         default: load_ext = dm_dout_i;
      endcase
   end

   // An ack in the final allowed cycle takes priority over the timeout.
   assign timeout_hit = busy && !dm_ack_i && (cnt_q == 8'(TIMEOUT - 1));
   assign wb_fire     = busy && dm_ack_i && is_load_q && (rd_q != 5'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = S_BUSY;
         cnt_d   = 8'd0;
      end else if (busy) begin
         if (dm_ack_i || timeout_hit) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         addr_q     <= 32'h0;
         wen_q      <= 32'h0;
         din_q      <= 32'h0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         rd_q       <= 5'd0;
         is_load_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_rd_q     <= 5'd0;
         m_data_q   <= 32'h0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         misalign_q <= op_ok && misaligned;
         bus_err_q  <= timeout_hit;
         m_valid_q  <= wb_fire;
         if (wb_fire) begin
            m_rd_q   <= rd_q;
            m_data_q <= load_ext;
         end
         if (accept) begin
            addr_q    <= {x_addr_i[31:2], 2'b00};
            wen_q     <= wen_n;
            din_q     <= din_n;
            funct3_q  <= x_funct3_i;
            off_q     <= x_addr_i[1:0];
            rd_q      <= x_rd_i;
            is_load_q <= x_load_i;
         end
      end
   end

   assign stall_o       = busy;
   assign dm_req_o      = busy;
   assign dm_addr_o     = addr_q;
   assign dm_wen_o      = wen_q;
   assign dm_din_o      = din_q;
   assign m_valid_o     = m_valid_q;
   assign m_rd_o        = m_rd_q;
   assign m_load_data_o = m_data_q;
   assign misalign_o    = misalign_q;
   assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomized bench for lsu; expectations come from a byte-lane model of RV32I memory ops.
module tb_lsu;

   logic        clk, rst;
   logic        x_valid, x_load, x_store;
   logic [2:0]  x_funct3;
   logic [31:0] x_addr, x_store_data;
   logic [4:0]  x_rd;
   logic        stall, dm_req, dm_ack;
   logic [31:0] dm_addr, dm_wen, dm_din, dm_dout;
   logic        m_valid, misalign, bus_err;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   int compared = 0;
   int mismatched = 0;
   logic [4:0]  last_rd = 5'd0;
   logic [31:0] last_data = 32'h0;

   lsu #(.TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .x_valid_i(x_valid), .x_load_i(x_load), .x_store_i(x_store),
      .x_funct3_i(x_funct3), .x_addr_i(x_addr), .x_store_data_i(x_store_data), .x_rd_i(x_rd),
      .stall_o(stall), .dm_req_o(dm_req), .dm_addr_o(dm_addr), .dm_wen_o(dm_wen),
      .dm_din_o(dm_din), .dm_dout_i(dm_dout), .dm_ack_i(dm_ack),
      .m_valid_o(m_valid), .m_rd_o(m_rd), .m_load_data_o(m_data),
      .misalign_o(misalign), .bus_err_o(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: an access touches nbytes consecutive byte lanes starting at addr%4.
   function automatic int unsigned nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic is_legal(input logic ld, input logic st, input logic [2:0] f3);
      if (ld == st) return 1'b0;
      if (ld) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      return (f3 == 0 || f3 == 1 || f3 == 2);
   endfunction

   function automatic logic [31:0] model_wen(input logic st, input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w = 32'h0;
      int unsigned off = a % 4;
      if (!st) return 32'h0;
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + nbytes(f3)) w = w | (32'hFF << (8 * i));
      return w;
   endfunction

   function automatic logic [31:0] model_din(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < 4; i++)
         r = r | (((d >> (8 * (i % nbytes(f3)))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      int unsigned n = nbytes(f3);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
      logic [31:0] v = (w >> (8 * (a % 4))) & mask;
      if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
      return v;
   endfunction

   // Presents one op for one cycle, answers the request ack_at cycles after acceptance
   // (ack_at >= 16 means never), and checks every visible consequence.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int ack_at, input logic [31:0] rdata);
      logic legal, mis, done;
      int   req_cycles, exp_req;
      x_valid = 1'b1; x_load = ld; x_store = st; x_funct3 = f3;
      x_addr = a; x_store_data = d; x_rd = rd;
      @(posedge clk); #1;
      x_valid = 1'b0; x_load = 1'b0; x_store = 1'b0;
      legal = is_legal(ld, st, f3);
      mis   = legal && ((a % nbytes(f3)) != 0);
      if (!legal) begin
         chk("ignored_stall", 32'(stall), 32'h0);
         chk("ignored_req", 32'(dm_req), 32'h0);
         chk("ignored_misalign", 32'(misalign), 32'h0);
         return;
      end
      if (mis) begin
         chk("misalign_pulse", 32'(misalign), 32'h1);
         chk("misalign_req", 32'(dm_req), 32'h0);
         chk("misalign_stall", 32'(stall), 32'h0);
         @(posedge clk); #1;
         chk("misalign_width", 32'(misalign), 32'h0);
         chk("misalign_req_after", 32'(dm_req), 32'h0);
         return;
      end
      chk("accept_stall", 32'(stall), 32'h1);
      chk("accept_dm_wen", dm_wen, model_wen(st, f3, a));
      chk("accept_dm_din", dm_din, model_din(f3, d));
      req_cycles = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c == ack_at) begin dm_ack = 1'b1; dm_dout = rdata; end
         if (dm_req) begin
            req_cycles++;
            chk("busy_dm_addr", dm_addr, {a[31:2], 2'b00});
         end
         @(posedge clk); #1;
         dm_ack = 1'b0; dm_dout = $urandom;
         if (!dm_req) done = 1'b1;
      end
      exp_req = (ack_at < 16) ? ack_at + 1 : 16;
      chk("req_cycles", 32'(req_cycles), 32'(exp_req));
      chk("done_stall", 32'(stall), 32'h0);
      if (ack_at < 16) begin
         chk("no_bus_err", 32'(bus_err), 32'h0);
         chk("m_valid", 32'(m_valid), 32'(ld && rd != 0));
         if (ld && rd != 0) begin
            last_rd = rd;
            last_data = model_load(f3, a, rdata);
            chk("m_rd", 32'(m_rd), 32'(last_rd));
            chk("m_load_data", m_data, last_data);
         end
      end else begin
         chk("bus_err_pulse", 32'(bus_err), 32'h1);
         chk("timeout_m_valid", 32'(m_valid), 32'h0);
      end
      @(posedge clk); #1;
      chk("pulse_end_m_valid", 32'(m_valid), 32'h0);
      chk("pulse_end_bus_err", 32'(bus_err), 32'h0);
      chk("hold_m_rd", 32'(m_rd), 32'(last_rd));
      chk("hold_m_data", m_data, last_data);
   endtask

   initial begin
      rst = 1'b1; x_valid = 1'b0; x_load = 1'b0; x_store = 1'b0; x_funct3 = 3'b000;
      x_addr = 32'h0; x_store_data = 32'h0; x_rd = 5'd0; dm_ack = 1'b0; dm_dout = 32'h0;
      #12;
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_dm_req", 32'(dm_req), 32'h0);
      chk("reset_dm_addr", dm_addr, 32'h0);
      chk("reset_dm_wen", dm_wen, 32'h0);
      chk("reset_dm_din", dm_din, 32'h0);
      chk("reset_m_valid", 32'(m_valid), 32'h0);
      chk("reset_m_rd", 32'(m_rd), 32'h0);
      chk("reset_m_data", m_data, 32'h0);
      chk("reset_misalign", 32'(misalign), 32'h0);
      chk("reset_bus_err", 32'(bus_err), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
      run_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd1, 1, 32'h80FF7F01);
      run_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd2, 0, 32'h80FF7F01);
      run_op(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 5'd3, 2, 32'h80FF7F01);
      run_op(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 5'd4, 0, 32'h80FF7F01);
      run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h12345678, 5'd0, 0, 32'h0);
      run_op(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd6, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd8, 100, 32'h0);
      run_op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 5'd9, 15, 32'hCAFEF00D);
      run_op(1'b1, 1'b0, 3'b000, 32'h600, 32'h0, 5'd0, 0, 32'h000000FF);
      run_op(1'b1, 1'b1, 3'b010, 32'h700, 32'h0, 5'd10, 0, 32'h0);
      run_op(1'b0, 1'b0, 3'b010, 32'h700, 32'h0, 5'd10, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'b011, 32'h700, 32'h0, 5'd10, 0, 32'h0);
      run_op(1'b0, 1'b1, 3'b100, 32'h700, 32'h0, 5'd10, 0, 32'h0);

      // An ack while idle must not produce anything.
      dm_ack = 1'b1; dm_dout = 32'h11111111;
      @(posedge clk); #1;
      dm_ack = 1'b0;
      chk("idle_ack_stall", 32'(stall), 32'h0);
      chk("idle_ack_m_valid", 32'(m_valid), 32'h0);

      // Asynchronous reset in the middle of an access.
      x_valid = 1'b1; x_load = 1'b1; x_store = 1'b0; x_funct3 = 3'b010; x_addr = 32'h400; x_rd = 5'd7;
      @(posedge clk); #1;
      x_valid = 1'b0; x_load = 1'b0;
      chk("rst_mid_busy_req", 32'(dm_req), 32'h1);
      @(posedge clk); #4;
      rst = 1'b1;
      #1;
      chk("rst_mid_req", 32'(dm_req), 32'h0);
      chk("rst_mid_stall", 32'(stall), 32'h0);
      chk("rst_mid_dm_addr", dm_addr, 32'h0);
      chk("rst_mid_m_rd", 32'(m_rd), 32'h0);
      chk("rst_mid_m_data", m_data, 32'h0);
      last_rd = 5'd0; last_data = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      dm_ack = 1'b1; dm_dout = 32'h22222222;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         dm_ack = 1'b0;
         chk("rst_no_m_valid", 32'(m_valid), 32'h0);
         chk("rst_no_stall", 32'(stall), 32'h0);
      end
      run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd7, 1, 32'h5A5A1234);

      for (int n = 0; n < 60; n++) begin
         logic ld, st;
         int   ack_at;
         case ($urandom_range(0, 9))
            0:       begin ld = 1'b1; st = 1'b1; end
            1:       begin ld = 1'b0; st = 1'b0; end
            2, 3, 4: begin ld = 1'b0; st = 1'b1; end
            default: begin ld = 1'b1; st = 1'b0; end
         endcase
         ack_at = ($urandom_range(0, 11) == 0) ? 100 : $urandom_range(0, 4);
         run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                ack_at, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
